// File: rtl/game_pkg.sv
// Shared types and constants for the rhythm-game round logic.
//   state_t    : round FSM states
//   TEMPO_LIM  : beat length in clk cycles, indexed by tempo_sel
//   pick_lim() : tempo lookup with the simulation-only fixed-limit override
package game_pkg;

   typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;

   localparam int ROW_W    = 8;
   localparam int WIN_ROWS = 5;
   localparam int CNT_W    = 23;

   // Element 0 is the rightmost entry.
   localparam logic [3:0][CNT_W-1:0] TEMPO_LIM =
      {23'd4180000, 23'd1672000, 23'd2508000, 23'd3344000};

   function automatic logic [CNT_W-1:0] pick_lim(input logic [1:0] sel, input int test_lim);
      if (test_lim != 0) return CNT_W'(test_lim);
      return TEMPO_LIM[sel];
   endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Song ROM fetch handshake.
//   row_req/row_addr  : sequencer -> ROM, request held until row_valid
//   row_data/row_valid: ROM -> sequencer, one-cycle response
interface round_sequencer_if;
   import game_pkg::*;

   logic             row_req;
   logic [7:0]       row_addr;
   logic [ROW_W-1:0] row_data;
   logic             row_valid;

   modport master (output row_req, row_addr, input  row_data, row_valid);
   modport slave  (input  row_req, row_addr, output row_data, row_valid);
endinterface

// File: rtl/round_sequencer_beat_timer.sv
// Beat-phase counter.
//   en      : count this cycle
//   clr     : force counter to 0 (has priority)
//   lim     : beat length; counter runs 0..lim-1
//   counter : current phase
//   wrap    : combinational, high on the enabled cycle where counter == lim-1
module beat_timer
   import game_pkg::*;
(
   input  logic             clk,
   input  logic             n_rst,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] lim,
   output logic [CNT_W-1:0] counter,
   output logic             wrap
);

   assign wrap = en && (counter == lim - CNT_W'(1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)             counter <= '0;
      else if (clr || wrap)   counter <= '0;
      else if (en)            counter <= counter + CNT_W'(1);
   end

endmodule

// File: rtl/round_sequencer.sv
// One play round of the rhythm game: beat timing, song-row fetch, note window,
// pause, end-of-song drain and final score latching.
//   start_btn/pause_btn : one-cycle pulses
//   tempo_sel/song_len  : sampled on start
//   rom                 : song ROM fetch handshake (master side)
//   counter/lim         : beat phase and active beat length for the scorer
//   padded_notes        : 5-row window, [7:0] newest, [39:32] at strike line
//   score_clear         : one-cycle scorer reset at round start
//   playing/done        : PLAY / DONE state flags
//   underrun            : sticky, a ROM row missed its beat
//   num_*/final_*       : live totals in, totals latched on entering DONE
module round_sequencer
   import game_pkg::*;
#(
   parameter int TEST_LIM   = 0,
   parameter int DRAIN_ROWS = 5   // must be >= 1
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      start_btn,
   input  logic                      pause_btn,
   input  logic [1:0]                tempo_sel,
   input  logic [7:0]                song_len,
   round_sequencer_if.master         rom,
   output logic [CNT_W-1:0]          counter,
   output logic [CNT_W-1:0]          lim,
   output logic [ROW_W*WIN_ROWS-1:0] padded_notes,
   output logic                      score_clear,
   output logic                      playing,
   output logic                      done,
   output logic                      underrun,
   input  logic [7:0]                num_hits,
   input  logic [7:0]                num_misses,
   output logic [7:0]                final_hits,
   output logic [7:0]                final_misses
);

   localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_ROWS - 1);

   state_t           state;
   logic [ROW_W-1:0] pending_row;
   logic [7:0]       song_len_q;
   logic [7:0]       drain_cnt;
   logic [7:0]       row_addr;
   logic             row_req;
   logic             fed_all;    // every song row has entered the window
   logic             run, start_go, wrap, capture, more_rows, last_out, finish;

   assign run       = (state == PLAY);
   assign start_go  = start_btn && (state == IDLE || state == DONE);
   assign capture   = row_req && rom.row_valid;
   assign more_rows = ({1'b0, row_addr} + 9'd1) < {1'b0, song_len_q};
   // Last row already requested and returned: it sits in pending_row now.
   assign last_out  = !more_rows && !row_req;
   assign finish    = wrap && fed_all && (drain_cnt == DRAIN_LAST);

   assign playing      = run;
   assign done         = (state == DONE);
   assign rom.row_req  = row_req;
   assign rom.row_addr = row_addr;

   beat_timer u_beat_timer (
      .clk     (clk),
      .n_rst   (n_rst),
      .en      (run),
      .clr     (start_go),
      .lim     (lim),
      .counter (counter),
      .wrap    (wrap)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= IDLE;
         lim          <= TEMPO_LIM[0];
         song_len_q   <= '0;
         padded_notes <= '0;
         pending_row  <= '0;
         row_req      <= 1'b0;
         row_addr     <= '0;
         underrun     <= 1'b0;
         drain_cnt    <= '0;
         fed_all      <= 1'b0;
         score_clear  <= 1'b0;
         final_hits   <= '0;
         final_misses <= '0;
      end else begin
         score_clear <= 1'b0;
         case (state)
            IDLE, DONE: if (start_btn) begin
               lim          <= pick_lim(tempo_sel, TEST_LIM);
               song_len_q   <= song_len;
               padded_notes <= '0;
               pending_row  <= '0;
               row_addr     <= '0;
               underrun     <= 1'b0;
               drain_cnt    <= '0;
               fed_all      <= (song_len == 8'd0);
               row_req      <= (song_len != 8'd0);
               score_clear  <= 1'b1;
               state        <= PLAY;
            end
            PLAY: begin
               if (wrap) begin
                  padded_notes <= {padded_notes[ROW_W*(WIN_ROWS-1)-1:0], pending_row};
                  pending_row  <= '0;
                  // A still-open request means this beat got no row; keep waiting.
                  if (row_req) underrun <= 1'b1;
                  else if (more_rows) begin
                     row_addr <= row_addr + 8'd1;
                     row_req  <= 1'b1;
                  end
                  if (fed_all)       drain_cnt <= drain_cnt + 8'd1;
                  else if (last_out) fed_all   <= 1'b1;
               end
               // Wrap completes first; end of song beats a coincident pause.
               if (finish) begin
                  state        <= DONE;
                  final_hits   <= num_hits;
                  final_misses <= num_misses;
               end else if (pause_btn) begin
                  state <= PAUSE;
               end
            end
            PAUSE: if (pause_btn) state <= PLAY;
            default: state <= IDLE;
         endcase
         // ROM responses are taken in any state, including PAUSE.
         if (capture) begin
            pending_row <= rom.row_data;
            row_req     <= 1'b0;
         end
      end
   end

endmodule
